mac_sequencer: RTL

Drives the product/start_accumulate stream into the row accumulator of the Tanh unit's matrix stage. Walks a ROWS×COLS signed weight matrix against a COLS-element activation vector held in external synchronous-read memories, forms one 17-bit signed product per cycle, and frames each row with start_accumulate. Flags the cycle in which the accumulator's registered 20-bit sum holds a complete row dot-product, so downstream Tanh logic can sample it.

---
 rtl/tanh_pkg.sv | 30 +++
 rtl/mac_sequencer_if.sv | 41 ++++
 rtl/mac_sequencer_addr_gen.sv | 60 ++++++
 rtl/mac_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared types and widths for the Tanh matrix stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tanh_pkg;

    localparam int PRODUCT_W = 17;
    localparam int SUM_W     = 20;
    localparam int W_W       = 9;
    localparam int X_W       = 8;
    localparam int ROW_TAG_W = 4;   // wide enough for up to 16 rows

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } seq_state_t;

    // Per-element tag travelling alongside the datapath
    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [ROW_TAG_W-1:0] row;
    } elem_tag_t;

    // Address width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Memory, accumulator and control bundle of the MAC sequencer.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; the optional hold is a plain port.
interface mac_sequencer_if
    import tanh_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) ();

    localparam int AW = clog2_min1(ROWS * COLS);
    localparam int XW = clog2_min1(COLS);
    localparam int RW = clog2_min1(ROWS);

    logic                 start;
    logic [AW-1:0]        w_addr;
    logic [W_W-1:0]       w_data;
    logic [XW-1:0]        x_addr;
    logic [X_W-1:0]       x_data;
    logic [PRODUCT_W-1:0] product;
    logic                 start_accumulate;
    logic                 sum_valid;
    logic [RW-1:0]        row_index;
    logic                 busy;
    logic                 done;

    // Sequencer side
    modport master (
        input  start, w_data, x_data,
        output w_addr, x_addr, product, start_accumulate,
               sum_valid, row_index, busy, done
    );

    // Memory / accumulator / controller side
    modport slave (
        output start, w_data, x_data,
        input  w_addr, x_addr, product, start_accumulate,
               sum_valid, row_index, busy, done
    );

endinterface

// File: rtl/mac_sequencer_addr_gen.sv
// Row/column walker: emits w_addr=r*COLS+c, x_addr=c and the element tag bits.
// Latency: addresses registered, valid the cycle after load/adv.
// Backpressure: holds its position whenever neither load nor adv is asserted.
module mac_addr_gen
    import tanh_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          adv,
    output logic [clog2_min1(ROWS*COLS)-1:0] w_addr,
    output logic [clog2_min1(COLS)-1:0]   x_addr,
    output logic [clog2_min1(ROWS)-1:0]   row,
    output logic                          first,
    output logic                          last,
    output logic                          final_elem
);

    localparam int AW = clog2_min1(ROWS * COLS);
    localparam int XW = clog2_min1(COLS);
    localparam int RW = clog2_min1(ROWS);
    localparam logic [XW-1:0] C_LAST = XW'(COLS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    logic [AW-1:0] k_q;
    logic [XW-1:0] c_q;
    logic [RW-1:0] r_q;

    // Flat index plus c-major column counter that wraps into the row counter
    always_ff @(posedge clock) begin
        if (reset) begin
            k_q <= '0;
            c_q <= '0;
            r_q <= '0;
        end else if (load) begin
            k_q <= '0;
            c_q <= '0;
            r_q <= '0;
        end else if (adv) begin
            k_q <= k_q + AW'(1);
            if (c_q == C_LAST) begin
                c_q <= '0;
                r_q <= r_q + RW'(1);
            end else begin
                c_q <= c_q + XW'(1);
            end
        end
    end

    assign w_addr     = k_q;
    assign x_addr     = c_q;
    assign row        = r_q;
    assign first      = (c_q == '0);
    assign last       = (c_q == C_LAST);
    assign final_elem = (c_q == C_LAST) && (r_q == R_LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Streams signed w*x products framed by start_accumulate into a row accumulator; flags complete row sums.
// Latency: product 2 cycles after its address, sum_valid 3 cycles after a row's last address.
// Backpressure: none by default; with MAC_SEQ_HOLD_EN the hold input freezes the whole pipeline.
module mac_sequencer
    import tanh_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic clock,
    input  logic reset,
`ifdef MAC_SEQ_HOLD_EN
    input  logic hold,
`endif
    mac_sequencer_if.master bus
);

    localparam int AW = clog2_min1(ROWS * COLS);
    localparam int XW = clog2_min1(COLS);
    localparam int RW = clog2_min1(ROWS);
    localparam logic [ROW_TAG_W-1:0] ROW_LAST = ROW_TAG_W'(ROWS - 1);

    seq_state_t state_q, state_d;

    logic                 stall;
    logic                 issue_load;
    logic                 issue_adv;
    logic                 vld_a;
    logic                 busy_int;
    logic                 final_elem;
    logic                 first_a;
    logic                 last_a;
    logic [RW-1:0]        row_a;
    logic [AW-1:0]        w_addr_a;
    logic [XW-1:0]        x_addr_a;
    elem_tag_t            tag_a, tag_b, tag_c;
    logic                 vld_b, vld_c, vld_d;
    logic                 last_d;
    logic [ROW_TAG_W-1:0] row_d;
    logic [W_W-1:0]       w_sel;
    logic [X_W-1:0]       x_sel;
    logic [PRODUCT_W-1:0] w_ext, x_ext, mult;
    logic [PRODUCT_W-1:0] product_q;
    logic                 sum_vld;
    logic                 done_int;

`ifdef MAC_SEQ_HOLD_EN
    logic           held_q;
    logic [W_W-1:0] w_skid_q;
    logic [X_W-1:0] x_skid_q;

    assign stall = hold;

    // The memory re-reads the frozen stage-A address during a stall, so the
    // stage-B operands are captured on the first stalled edge and replayed
    // in the cycle the stall releases.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_q   <= 1'b0;
            w_skid_q <= '0;
            x_skid_q <= '0;
        end else begin
            held_q <= hold;
            if (hold && !held_q) begin
                w_skid_q <= bus.w_data;
                x_skid_q <= bus.x_data;
            end
        end
    end

    assign w_sel = held_q ? w_skid_q : bus.w_data;
    assign x_sel = held_q ? x_skid_q : bus.x_data;
`else
    assign stall = 1'b0;
    assign w_sel = bus.w_data;
    assign x_sel = bus.x_data;
`endif

    mac_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load       (issue_load),
        .adv        (issue_adv),
        .w_addr     (w_addr_a),
        .x_addr     (x_addr_a),
        .row        (row_a),
        .first      (first_a),
        .last       (last_a),
        .final_elem (final_elem)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; ISSUE lasts while stage A holds a live element
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                IDLE:    if (bus.start) state_d = ISSUE;
                ISSUE:   if (final_elem) state_d = DRAIN;
                DRAIN:   if (done_int) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: counter control and stage-A validity
    always_comb begin
        busy_int   = (state_q != IDLE);
        vld_a      = (state_q == ISSUE);
        issue_load = (state_q == IDLE) && bus.start && !stall;
        issue_adv  = (state_q == ISSUE) && !final_elem && !stall;
    end

    assign tag_a = '{first: first_a, last: last_a, row: ROW_TAG_W'(row_a)};

    // Full-precision signed multiply via explicit sign extension
    assign w_ext = {{(PRODUCT_W - W_W){w_sel[W_W-1]}}, w_sel};
    assign x_ext = {{(PRODUCT_W - X_W){x_sel[X_W-1]}}, x_sel};
    assign mult  = w_ext * x_ext;

    // Tag/data pipeline: address -> memory data -> product -> accumulator
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_b     <= 1'b0;
            vld_c     <= 1'b0;
            vld_d     <= 1'b0;
            tag_b     <= '0;
            tag_c     <= '0;
            last_d    <= 1'b0;
            row_d     <= '0;
            product_q <= '0;
        end else if (!stall) begin
            vld_b     <= vld_a;
            tag_b     <= vld_a ? tag_a : '0;
            vld_c     <= vld_b;
            tag_c     <= vld_b ? tag_b : '0;
            product_q <= vld_b ? mult : '0;
            vld_d     <= vld_c;
            last_d    <= vld_c && tag_c.last;
            row_d     <= vld_c ? tag_c.row : '0;
        end
    end

    // An empty product stage restarts the accumulator at zero; a stall adds zero
    assign sum_vld  = !stall && vld_d && last_d;
    assign done_int = sum_vld && (row_d == ROW_LAST);

    assign bus.w_addr           = w_addr_a;
    assign bus.x_addr           = x_addr_a;
    assign bus.product          = stall ? '0 : product_q;
    assign bus.start_accumulate = stall ? 1'b0 : (!vld_c || tag_c.first);
    assign bus.sum_valid        = sum_vld;
    assign bus.row_index        = row_d[RW-1:0];
    assign bus.busy             = busy_int;
    assign bus.done             = done_int;

endmodule
